// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment animation path: button roles and
// default speed/debounce settings used by seg7_anim_ctrl.
package seg7_pkg;

  localparam int BTN_ANI_INC = 0;
  localparam int BTN_ANI_DEC = 1;
  localparam int BTN_SLOWER  = 2;
  localparam int BTN_FASTER  = 3;

  localparam int unsigned CMP_DEF_VAL    = 10_000_000;
  localparam int unsigned CMP_MIN_VAL    = 1_000_000;
  localparam int unsigned CMP_MAX_VAL    = 20_000_000;
  localparam int unsigned CMP_STEP_VAL   = 1_000_000;
  localparam int unsigned DEB_CYCLES_VAL = 512;

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchroniser, counter debouncer, and a one-cycle
// event on each accepted press plus optional auto-repeat while held.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES   = 512,
  parameter int unsigned REPEAT_EN    = 1,
  parameter int unsigned REPEAT_DELAY = 5_000_000,
  parameter int unsigned REPEAT_RATE  = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic evt
);

  localparam int unsigned DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

  logic [1:0]       sync;
  logic             stable;
  logic [DEB_W-1:0] deb_cnt;
  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_on;
  logic             accept;
  logic             rpt_fire;

  // accept marks the edge on which the stable level flips
  assign accept   = (sync[1] != stable) && (deb_cnt == DEB_LAST);
  assign rpt_fire = (REPEAT_EN != 0) && stable && !accept &&
                    (rpt_cnt == (rpt_on ? RATE_LAST : DELAY_LAST));

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '0;
      stable  <= 1'b0;
      deb_cnt <= '0;
      rpt_cnt <= '0;
      rpt_on  <= 1'b0;
      evt     <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      evt  <= (accept && !stable) || rpt_fire;

      if (accept) begin
        stable  <= ~stable;
        deb_cnt <= '0;
      end else if (sync[1] != stable) begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end else begin
        deb_cnt <= '0;
      end

      // Repeat timer restarts on every level change and idles while released
      if (!stable || accept || REPEAT_EN == 0) begin
        rpt_cnt <= '0;
        rpt_on  <= 1'b0;
      end else if (rpt_fire) begin
        rpt_cnt <= '0;
        rpt_on  <= 1'b1;
      end else begin
        rpt_cnt <= rpt_cnt + RPT_W'(1);
      end
    end
  end

endmodule

// File: rtl/seg7_anim_ctrl.sv
// Button-driven animation index and speed control, plus the step prescaler
// and digit counter that feed the segment lookup.
module seg7_anim_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_ANI      = 64,
  parameter int unsigned ANI_W        = 6,
  parameter int unsigned DIGIT_W      = 5,
  parameter int unsigned CMP_W        = 25,
  parameter int unsigned CMP_DEF      = CMP_DEF_VAL,
  parameter int unsigned CMP_MIN      = CMP_MIN_VAL,
  parameter int unsigned CMP_MAX      = CMP_MAX_VAL,
  parameter int unsigned CMP_STEP     = CMP_STEP_VAL,
  parameter int unsigned DEB_CYCLES   = DEB_CYCLES_VAL,
  parameter int unsigned REPEAT_EN    = 1,
  parameter int unsigned REPEAT_DELAY = 5_000_000,
  parameter int unsigned REPEAT_RATE  = 1_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [3:0]         btn,
  input  logic [DIGIT_W-1:0] limit,
  output logic [ANI_W-1:0]   ani,
  output logic [DIGIT_W-1:0] digit,
  output logic               tick,
  output logic [CMP_W-1:0]   compare,
  output logic [3:0]         evt
);

  localparam logic [ANI_W-1:0] ANI_LAST   = ANI_W'(NUM_ANI - 1);
  localparam logic [CMP_W:0]   CMP_MAX_X  = (CMP_W+1)'(CMP_MAX);
  localparam logic [CMP_W:0]   CMP_MIN_X  = (CMP_W+1)'(CMP_MIN);
  localparam logic [CMP_W:0]   CMP_STEP_X = (CMP_W+1)'(CMP_STEP);

  logic [ANI_W-1:0] ani_next;
  logic             ani_chg;
  logic [CMP_W-1:0] cmp_next;
  logic [CMP_W:0]   cmp_up;
  logic [CMP_W:0]   cmp_dn;
  logic [CMP_W-1:0] presc;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEB_CYCLES  (DEB_CYCLES),
      .REPEAT_EN   (REPEAT_EN),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (btn[i]),
      .evt  (evt[i])
    );
  end

  // NOTE: defaults first so no path through the block leaves a latch.
  always_comb begin
    ani_next = ani;
    if (evt[BTN_ANI_INC] && !evt[BTN_ANI_DEC])
      ani_next = (ani == ANI_LAST) ? '0 : ani + ANI_W'(1);
    else if (evt[BTN_ANI_DEC] && !evt[BTN_ANI_INC])
      ani_next = (ani == '0) ? ANI_LAST : ani - ANI_W'(1);
    ani_chg = (ani_next != ani);

    // One spare bit so the sum and the borrow test cannot wrap
    cmp_up   = {1'b0, compare} + CMP_STEP_X;
    cmp_dn   = {1'b0, compare} - CMP_STEP_X;
    cmp_next = compare;
    if (evt[BTN_SLOWER] && !evt[BTN_FASTER])
      cmp_next = (cmp_up > CMP_MAX_X) ? CMP_W'(CMP_MAX) : cmp_up[CMP_W-1:0];
    else if (evt[BTN_FASTER] && !evt[BTN_SLOWER])
      cmp_next = ({1'b0, compare} < CMP_MIN_X + CMP_STEP_X) ? CMP_W'(CMP_MIN)
                                                           : cmp_dn[CMP_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ani     <= '0;
      compare <= CMP_W'(CMP_DEF);
      presc   <= '0;
      tick    <= 1'b0;
      digit   <= '0;
    end else begin
      ani     <= ani_next;
      compare <= cmp_next;

      // A new animation restarts from its first step with a full period
      if (ani_chg) begin
        presc <= '0;
        tick  <= 1'b0;
        digit <= '0;
      end else if (ena) begin
        if (presc >= compare) begin
          presc <= '0;
          tick  <= 1'b1;
        end else begin
          presc <= presc + CMP_W'(1);
          tick  <= 1'b0;
        end
        if (tick)
          digit <= (digit >= limit) ? '0 : digit + DIGIT_W'(1);
      end else begin
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_anim_ctrl.sv
// Directed bench for seg7_anim_ctrl with small timing parameters so that
// debounce, repeat, wrap, saturation and prescaler behaviour fit in short runs.
module tb_seg7_anim_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [3:0]  btn;
  logic [4:0]  limit;
  logic [2:0]  ani;
  logic [4:0]  digit;
  logic        tick;
  logic [24:0] compare;
  logic [3:0]  evt;

  int n_cmp = 0;
  int n_bad = 0;
  int evt_cnt [4];

  seg7_anim_ctrl #(
    .NUM_ANI(5), .ANI_W(3), .DIGIT_W(5), .CMP_W(25),
    .CMP_DEF(10), .CMP_MIN(2), .CMP_MAX(20), .CMP_STEP(4),
    .DEB_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(20), .REPEAT_RATE(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .btn(btn), .limit(limit),
    .ani(ani), .digit(digit), .tick(tick), .compare(compare), .evt(evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    for (int i = 0; i < 4; i++) if (evt[i]) evt_cnt[i]++;

  // Holds btn[idx] for edges 0..7 and snapshots the outputs after edge 6,
  // where a single press lands; nt is the first later edge carrying a tick.
  task automatic press(input int idx, output logic [2:0] a6, output logic [4:0] d6,
                       output logic t6, output int nt);
    btn[idx] = 1'b1;
    nt = -1;
    a6 = '0; d6 = '0; t6 = 1'b0;
    for (int k = 0; k <= 22; k++) begin
      @(negedge clk);
      if (k == 7) btn[idx] = 1'b0;
      if (k == 6) begin a6 = ani; d6 = digit; t6 = tick; end
      if (k > 6 && nt < 0 && tick) nt = k;
    end
  endtask

  task automatic test_reset;
    logic       exp_t;
    logic [4:0] exp_d;
    rst_n = 1'b0; ena = 1'b1; btn = '0; limit = 5'd3;
    repeat (3) @(negedge clk);
    n_cmp++; if (ani !== 3'd0)       begin n_bad++; $display("FAIL rst_ani got %0d want 0", ani); end
    n_cmp++; if (digit !== 5'd0)     begin n_bad++; $display("FAIL rst_digit got %0d want 0", digit); end
    n_cmp++; if (tick !== 1'b0)      begin n_bad++; $display("FAIL rst_tick got %0b want 0", tick); end
    n_cmp++; if (compare !== 25'd10) begin n_bad++; $display("FAIL rst_compare got %0d want 10", compare); end
    n_cmp++; if (evt !== 4'd0)       begin n_bad++; $display("FAIL rst_evt got %b want 0000", evt); end
    rst_n = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      exp_t = (k % 11 == 0);
      exp_d = 5'(((k - 1) / 11) % 4);
      n_cmp++; if (tick !== exp_t)  begin n_bad++; $display("FAIL presc_tick edge %0d got %0b want %0b", k, tick, exp_t); end
      n_cmp++; if (digit !== exp_d) begin n_bad++; $display("FAIL presc_digit edge %0d got %0d want %0d", k, digit, exp_d); end
    end
    n_cmp++; if (ani !== 3'd0)       begin n_bad++; $display("FAIL presc_ani got %0d want 0", ani); end
    n_cmp++; if (compare !== 25'd10) begin n_bad++; $display("FAIL presc_compare got %0d want 10", compare); end
  endtask

  task automatic test_debounce;
    int e0;
    e0 = evt_cnt[0];
    btn[0] = 1'b1;
    repeat (3) @(negedge clk);
    btn[0] = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++; if (evt_cnt[0] !== e0) begin n_bad++; $display("FAIL glitch_evt got %0d want %0d", evt_cnt[0], e0); end
    n_cmp++; if (ani !== 3'd0)      begin n_bad++; $display("FAIL glitch_ani got %0d want 0", ani); end

    btn[0] = 1'b1;
    for (int k = 0; k <= 34; k++) begin
      @(negedge clk);
      case (k)
        5: begin
          n_cmp++; if (ani !== 3'd0)    begin n_bad++; $display("FAIL hold_ani@5 got %0d want 0", ani); end
          n_cmp++; if (evt[0] !== 1'b1) begin n_bad++; $display("FAIL hold_evt@5 got %0b want 1", evt[0]); end
        end
        6: begin
          n_cmp++; if (ani !== 3'd1)    begin n_bad++; $display("FAIL hold_ani@6 got %0d want 1", ani); end
          n_cmp++; if (evt[0] !== 1'b0) begin n_bad++; $display("FAIL hold_evt@6 got %0b want 0", evt[0]); end
        end
        25: begin n_cmp++; if (ani !== 3'd1) begin n_bad++; $display("FAIL hold_ani@25 got %0d want 1", ani); end end
        26: begin n_cmp++; if (ani !== 3'd2) begin n_bad++; $display("FAIL hold_ani@26 got %0d want 2", ani); end end
        33: begin n_cmp++; if (ani !== 3'd2) begin n_bad++; $display("FAIL hold_ani@33 got %0d want 2", ani); end end
        34: begin n_cmp++; if (ani !== 3'd3) begin n_bad++; $display("FAIL hold_ani@34 got %0d want 3", ani); end end
        default: ;
      endcase
    end
    btn[0] = 1'b0;
    repeat (60) @(negedge clk);
    n_cmp++; if (ani !== 3'd3)           begin n_bad++; $display("FAIL release_ani got %0d want 3", ani); end
    n_cmp++; if (evt_cnt[0] !== e0 + 3)  begin n_bad++; $display("FAIL release_evts got %0d want %0d", evt_cnt[0], e0 + 3); end
  endtask

  task automatic test_wrap_clear;
    logic [2:0] a6;
    logic [4:0] d6;
    logic       t6;
    int         nt;
    int         idx [4]     = '{0, 0, 1, 0};
    logic [2:0] exp_a [4]   = '{3'd4, 3'd0, 3'd4, 3'd0};
    for (int w = 0; w < 60 && digit == 5'd0; w++) @(negedge clk);
    n_cmp++; if (digit === 5'd0) begin n_bad++; $display("FAIL wrap_pre_digit got 0 want nonzero"); end
    for (int p = 0; p < 4; p++) begin
      press(idx[p], a6, d6, t6, nt);
      n_cmp++; if (a6 !== exp_a[p]) begin n_bad++; $display("FAIL wrap_ani[%0d] got %0d want %0d", p, a6, exp_a[p]); end
      n_cmp++; if (d6 !== 5'd0)     begin n_bad++; $display("FAIL wrap_digit[%0d] got %0d want 0", p, d6); end
      n_cmp++; if (t6 !== 1'b0)     begin n_bad++; $display("FAIL wrap_tick[%0d] got %0b want 0", p, t6); end
      n_cmp++; if (nt !== 17)       begin n_bad++; $display("FAIL wrap_next_tick[%0d] got edge %0d want 17", p, nt); end
    end
  endtask

  task automatic test_saturation;
    logic [2:0]  a6;
    logic [4:0]  d6;
    logic        t6;
    int          nt;
    logic [24:0] up [4] = '{25'd14, 25'd18, 25'd20, 25'd20};
    logic [24:0] dn [6] = '{25'd16, 25'd12, 25'd8, 25'd4, 25'd2, 25'd2};
    for (int p = 0; p < 4; p++) begin
      press(2, a6, d6, t6, nt);
      n_cmp++; if (compare !== up[p]) begin n_bad++; $display("FAIL slower[%0d] got %0d want %0d", p, compare, up[p]); end
    end
    for (int p = 0; p < 6; p++) begin
      press(3, a6, d6, t6, nt);
      n_cmp++; if (compare !== dn[p]) begin n_bad++; $display("FAIL faster[%0d] got %0d want %0d", p, compare, dn[p]); end
    end
    n_cmp++; if (ani !== 3'd0) begin n_bad++; $display("FAIL sat_ani got %0d want 0", ani); end
  endtask

  task automatic test_simultaneous_ena;
    int         e0, e1;
    logic [4:0] d_hold;
    e0 = evt_cnt[0]; e1 = evt_cnt[1];
    btn = 4'b0011;
    repeat (8) @(negedge clk);
    btn = 4'b0000;
    repeat (15) @(negedge clk);
    n_cmp++; if (ani !== 3'd0)          begin n_bad++; $display("FAIL simul_ani got %0d want 0", ani); end
    n_cmp++; if (evt_cnt[0] !== e0 + 1) begin n_bad++; $display("FAIL simul_evt0 got %0d want %0d", evt_cnt[0], e0 + 1); end
    n_cmp++; if (evt_cnt[1] !== e1 + 1) begin n_bad++; $display("FAIL simul_evt1 got %0d want %0d", evt_cnt[1], e1 + 1); end

    ena = 1'b0;
    d_hold = digit;
    btn[2] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 7) btn[2] = 1'b0;
      n_cmp++; if (tick !== 1'b0)    begin n_bad++; $display("FAIL ena_tick @%0d got %0b want 0", k, tick); end
      n_cmp++; if (digit !== d_hold) begin n_bad++; $display("FAIL ena_digit @%0d got %0d want %0d", k, digit, d_hold); end
    end
    n_cmp++; if (compare !== 25'd6) begin n_bad++; $display("FAIL ena_compare got %0d want 6", compare); end
    ena = 1'b1;
  endtask

  task automatic test_async_reset;
    logic [2:0] a6;
    logic [4:0] d6;
    logic       t6;
    int         nt;
    repeat (3) press(0, a6, d6, t6, nt);
    repeat (3) press(2, a6, d6, t6, nt);
    n_cmp++; if (ani !== 3'd3)       begin n_bad++; $display("FAIL pre_rst_ani got %0d want 3", ani); end
    n_cmp++; if (compare !== 25'd18) begin n_bad++; $display("FAIL pre_rst_compare got %0d want 18", compare); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (ani !== 3'd0)       begin n_bad++; $display("FAIL arst_ani got %0d want 0", ani); end
    n_cmp++; if (digit !== 5'd0)     begin n_bad++; $display("FAIL arst_digit got %0d want 0", digit); end
    n_cmp++; if (tick !== 1'b0)      begin n_bad++; $display("FAIL arst_tick got %0b want 0", tick); end
    n_cmp++; if (compare !== 25'd10) begin n_bad++; $display("FAIL arst_compare got %0d want 10", compare); end
    n_cmp++; if (evt !== 4'd0)       begin n_bad++; $display("FAIL arst_evt got %b want 0000", evt); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) evt_cnt[i] = 0;
    test_reset();
    test_debounce();
    test_wrap_clear();
    test_saturation();
    test_simultaneous_ena();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_anim_ctrl.md
# seg7_anim_ctrl

Parametrised animation and speed controller for the 7-segment display path. It debounces N_BTN push-buttons with single-pulse press events and auto-repeat, and keeps a wrap-around animation index and a saturating speed compare value. It also generates the animation step tick and the digit counter that feed the segment lookup. It sits between the `ui_in` button pins and the segment decoder and limit lookup.

## Interface
- `NUM_ANI`, 64: number of animations; index range 0..NUM_ANI-1
- `ANI_W`, 6: width of the animation index; must satisfy 2^ANI_W >= NUM_ANI
- `DIGIT_W`, 5: width of the digit counter
- `CMP_W`, 25: width of the compare value and the prescaler
- `CMP_DEF`, 10_000_000: compare value after reset
- `CMP_MIN`, 1_000_000: lower saturation bound of the compare value
- `CMP_MAX`, 20_000_000: upper saturation bound of the compare value
- `CMP_STEP`, 1_000_000: compare increment/decrement per event
- `DEB_CYCLES`, 512: number of consecutive stable cycles required to accept a new button level
- `REPEAT_EN`, 1: enables auto-repeat
- `REPEAT_DELAY`, 5_000_000: cycles from a press event to the first repeat event
- `REPEAT_RATE`, 1_000_000: cycles between subsequent repeat events
- `clk` in 1: single clock
- `rst_n` in 1: asynchronous, active-low reset
- `ena` in 1: high enables the prescaler and the digit counter
- `btn` in 4: raw asynchronous buttons; [0] ani+1, [1] ani-1, [2] compare+STEP (slower), [3] compare-STEP (faster)
- `limit` in DIGIT_W: last digit value for the current animation, supplied by the limit lookup
- `ani` out ANI_W: current animation index
- `digit` out DIGIT_W: current animation step
- `tick` out 1: one-cycle pulse on each animation step
- `compare` out CMP_W: current compare value
- `evt` out 4: one-cycle press/repeat event per button, for observation

## Operation
- All outputs reset to: `ani` 0, `digit` 0, `tick` 0, `compare` CMP_DEF, `evt` 0. Debouncer state and counters reset to 0.
- **Debouncer, one per button:**
  - 2-flop synchroniser.
  - Stable-level register plus a counter. The counter increments while the synchronised input differs from the stable level and clears otherwise.
  - When the counter reaches DEB_CYCLES-1 while the difference persists, the stable level toggles and the counter clears.
  - A rise of the stable level produces one `evt` pulse.
  - With REPEAT_EN, a repeat counter runs while the stable level is high: one `evt` pulse REPEAT_DELAY cycles after the press, then one every REPEAT_RATE cycles.
  - A falling stable level stops the repeat counter and clears it.
- **Animation index:**
  - `evt[0]` alone: ani+1, wrapping NUM_ANI-1 -> 0.
  - `evt[1]` alone: ani-1, wrapping 0 -> NUM_ANI-1.
  - `evt[0]` and `evt[1]` in the same cycle: no change.
- **Any change of `ani`:** `digit` and the prescaler clear on the same edge, and no `tick` is issued on that edge.
- **Speed:**
  - `evt[2]`: compare = min(compare+CMP_STEP, CMP_MAX).
  - `evt[3]`: compare = max(compare-CMP_STEP, CMP_MIN).
  - Both in the same cycle: no change.
  - Arithmetic is computed at CMP_W+1 bits so it cannot overflow.
- **Prescaler:**
  - With `ena` high: if prescaler >= compare, the prescaler goes to 0 and `tick` is 1 for that cycle; otherwise it increments.
  - The period is compare+1 cycles.
  - Using >= means that lowering compare below the current count ticks on the next cycle.
- **Digit:** on `tick`, if digit >= limit then 0, else digit+1.
- **`ena` low:** prescaler, `tick` and `digit` hold, with `tick` 0. Debouncers, `ani` and `compare` stay active.

## Timing
- All state updates on the rising edge of `clk`. `rst_n` assertion clears all state immediately, with no clock needed. Deassertion is synchronised externally.
- **Button latency:** with `btn` first sampled high at edge 0:
  - stable level rises at edge DEB_CYCLES+1;
  - `evt` is high during the following cycle;
  - `ani`/`compare` update at edge DEB_CYCLES+2.
- **Release latency:** the same DEB_CYCLES+1 edges. No event is generated on release.
- `tick` is a registered output, high for exactly one cycle.
- `digit` updates on the edge after `tick` is high.

## Structure
- Package `seg7_pkg`:
  - button index constants (BTN_ANI_INC=0, BTN_ANI_DEC=1, BTN_SLOWER=2, BTN_FASTER=3);
  - default CMP_* and DEB_CYCLES values.
- Sub-module `btn_debounce` holds the synchroniser, debouncer and repeat logic. It has parameters DEB_CYCLES, REPEAT_EN, REPEAT_DELAY and REPEAT_RATE. It is instantiated 4 times via generate.
- The top level holds the animation index, speed, prescaler and digit logic.

## Test plan
Parameters for all scenarios: NUM_ANI=5, DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8, CMP_DEF=10, CMP_MIN=2, CMP_MAX=20, CMP_STEP=4, `ena`=1, `limit`=3.
- **Reset / prescaler:** release `rst_n` -> `tick` every 11 cycles; `digit` runs 0,1,2,3,0; `ani`=0; `compare`=10.
- **Debounce and repeat:**
  - `btn[0]` high for 3 cycles -> no `evt`, `ani`=0.
  - `btn[0]` held -> `ani`=1 at edge 6, 2 at edge 26, 3 at edge 34.
  - Release -> no further change.
- **Wrap and clear:**
  - From `ani`=0, press `btn[1]` -> `ani`=4.
  - Press `btn[0]` -> `ani`=0.
  - `digit` and the prescaler are 0 after each change.
- **Saturation:**
  - From 10, three `btn[2]` presses -> `compare` 14, 18, 20; a fourth press -> 20.
  - Then six `btn[3]` presses -> 16, 12, 8, 4, 2, 2.
- **Simultaneous / `ena`:**
  - `btn[0]` and `btn[1]` pressed on the same cycle -> `ani` unchanged.
  - `ena`=0 for 30 cycles -> `digit` frozen and `tick` 0, while button events are still applied.
- **Async reset mid-operation:** drop `rst_n` between clock edges with `ani`=3 and `compare`=18 -> all outputs at reset values before the next edge.
